// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - state encodings and word layouts for the block dispatch control unit
package dispatch_pkg;

   typedef enum logic [3:0] {
      S_IDLE         = 4'd0,
      S_REQ_CFG      = 4'd1,
      S_READ_CFG     = 4'd2,
      S_LATCH_CFG    = 4'd3,
      S_SCATTER      = 4'd4,
      S_WAIT_DONE    = 4'd5,
      S_REQ_STATUS   = 4'd6,
      S_WRITE_STATUS = 4'd7
   } state_t;

   // Config fields are counted in units of IDX_W bits.
   localparam int CFG_ROWS_FIELD = 0;
   localparam int CFG_COLS_FIELD = 1;

   localparam int STATUS_DONE_BIT  = 0;
   localparam int STATUS_TILES_LSB = 1;

endpackage

// File: rtl/dispatch_priority_enc.sv
// rtl/dispatch_priority_enc.sv - lowest-set-bit one-hot select over the free processor vector
module dispatch_priority_enc #(
   parameter int P = 4
) (
   input  logic [P-1:0] i_free,
   output logic [P-1:0] o_onehot,
   output logic         o_any
);

   always_comb begin
      o_onehot = '0;
      o_any    = 1'b0;
      for (int k = 0; k < P; k++) begin
         if (i_free[k] && !o_any) begin
            o_onehot[k] = 1'b1;
            o_any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/block_dispatch_cu.sv
// rtl/block_dispatch_cu.sv - reads a job config, scatters R x C block indices to idle processors, writes status
module block_dispatch_cu
   import dispatch_pkg::*;
#(
   parameter int          P           = 4,
   parameter int          IDX_W       = 8,
   parameter int          ADDR_W      = 16,
   parameter int          DATA_W      = 32,
   parameter int unsigned CFG_ADDR    = 0,
   parameter int unsigned STATUS_ADDR = 1
) (
   input  logic              i_Clock,
   input  logic              i_Reset_n,
   input  logic              i_Data_Ready,
   output logic              o_Grant_Request,
   input  logic              i_Grant,
   output logic [ADDR_W-1:0] o_Memory_Address,
   output logic              o_Memory_Write_En,
   output logic [DATA_W-1:0] o_Memory_Write_Data,
   input  logic [DATA_W-1:0] i_Memory_Read_Data,
   output logic [DATA_W-1:0] o_Config,
   output logic [IDX_W-1:0]  o_Row_Index,
   output logic [IDX_W-1:0]  o_Column_Index,
   output logic [P-1:0]      o_Indexes_Ready,
   input  logic [P-1:0]      i_Indexes_Received,
   input  logic [P-1:0]      i_Result_Ready,
   output logic              o_Busy,
   output logic              o_Done,
   output logic              o_Error
);

   localparam int CNT_W = 2 * IDX_W;

   state_t            state_q, state_d;
   logic              dr_prev_q, dr_prev_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [CNT_W-1:0]  tile_q, tile_d;
   logic [CNT_W-1:0]  cmpl_q, cmpl_d;
   logic [IDX_W-1:0]  row_q, row_d;
   logic [IDX_W-1:0]  col_q, col_d;
   logic [P-1:0]      offer_q, offer_d;
   logic [P-1:0]      pbusy_q, pbusy_d;

   logic [P-1:0]      free_onehot;
   logic              any_free;
   logic [P-1:0]      cmpl_hit;
   logic [CNT_W-1:0]  cmpl_inc;
   logic [CNT_W-1:0]  tile_next;
   logic [IDX_W-1:0]  col_next;
   logic [IDX_W-1:0]  rd_rows, rd_cols, cfg_cols;
   logic [DATA_W-1:0] status_word;
   logic              tracking;

   assign rd_rows  = i_Memory_Read_Data[CFG_ROWS_FIELD*IDX_W +: IDX_W];
   assign rd_cols  = i_Memory_Read_Data[CFG_COLS_FIELD*IDX_W +: IDX_W];
   assign cfg_cols = cfg_q[CFG_COLS_FIELD*IDX_W +: IDX_W];

   dispatch_priority_enc #(.P(P)) u_prio (
      .i_free   (~pbusy_q),
      .o_onehot (free_onehot),
      .o_any    (any_free)
   );

   always_comb begin
      state_d   = state_q;
      dr_prev_d = i_Data_Ready;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      cfg_d     = cfg_q;
      total_d   = total_q;
      tile_d    = tile_q;
      cmpl_d    = cmpl_q;
      row_d     = row_q;
      col_d     = col_q;
      offer_d   = offer_q;
      pbusy_d   = pbusy_q;

      o_Grant_Request     = 1'b0;
      o_Memory_Address    = '0;
      o_Memory_Write_En   = 1'b0;
      o_Memory_Write_Data = '0;

      cmpl_hit    = '0;
      cmpl_inc    = '0;
      tile_next   = tile_q + CNT_W'(1);
      col_next    = col_q + IDX_W'(1);
      status_word = '0;
      status_word[STATUS_DONE_BIT]            = 1'b1;
      status_word[STATUS_TILES_LSB +: CNT_W] = total_q;

      // Completions are only meaningful once the job's tile count is known.
      tracking = (state_q == S_SCATTER) || (state_q == S_WAIT_DONE) ||
                 (state_q == S_REQ_STATUS) || (state_q == S_WRITE_STATUS);
      if (tracking) begin
         cmpl_hit = i_Result_Ready & pbusy_q;
         for (int k = 0; k < P; k++) begin
            if (cmpl_hit[k]) cmpl_inc = cmpl_inc + CNT_W'(1);
         end
         pbusy_d = pbusy_q & ~cmpl_hit;
         cmpl_d  = cmpl_q + cmpl_inc;
         if ((i_Result_Ready & ~pbusy_q) != '0) err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_Data_Ready && !dr_prev_q) begin
               state_d = S_REQ_CFG;
               busy_d  = 1'b1;
               tile_d  = '0;
               cmpl_d  = '0;
               pbusy_d = '0;
               offer_d = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_REQ_CFG: begin
            o_Grant_Request = 1'b1;
            if (i_Grant) state_d = S_READ_CFG;
         end
         S_READ_CFG: begin
            o_Grant_Request  = 1'b1;
            o_Memory_Address = ADDR_W'(CFG_ADDR);
            state_d          = i_Grant ? S_LATCH_CFG : S_REQ_CFG;
         end
         S_LATCH_CFG: begin
            // Request stays up until the data is safely latched under grant.
            o_Grant_Request = 1'b1;
            if (!i_Grant) begin
               state_d = S_REQ_CFG;
            end else begin
               cfg_d   = i_Memory_Read_Data;
               total_d = CNT_W'(rd_rows) * CNT_W'(rd_cols);
               row_d   = '0;
               col_d   = '0;
               state_d = (rd_rows == '0 || rd_cols == '0) ? S_REQ_STATUS : S_SCATTER;
            end
         end
         S_SCATTER: begin
            if (offer_q != '0) begin
               if ((offer_q & i_Indexes_Received) != '0) begin
                  offer_d = '0;
                  pbusy_d = pbusy_d | offer_q;
                  tile_d  = tile_next;
                  if (col_next == cfg_cols) begin
                     col_d = '0;
                     row_d = row_q + IDX_W'(1);
                  end else begin
                     col_d = col_next;
                  end
                  if (tile_next == total_q) state_d = S_WAIT_DONE;
               end
            end else if (any_free) begin
               offer_d = free_onehot;
            end
         end
         S_WAIT_DONE: begin
            if (cmpl_q == total_q) state_d = S_REQ_STATUS;
         end
         S_REQ_STATUS: begin
            o_Grant_Request = 1'b1;
            if (i_Grant) state_d = S_WRITE_STATUS;
         end
         S_WRITE_STATUS: begin
            o_Grant_Request  = 1'b1;
            o_Memory_Address = ADDR_W'(STATUS_ADDR);
            if (i_Grant) begin
               o_Memory_Write_En   = 1'b1;
               o_Memory_Write_Data = status_word;
               state_d             = S_IDLE;
               busy_d              = 1'b0;
               done_d              = 1'b1;
            end else begin
               state_d = S_REQ_STATUS;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q   <= S_IDLE;
         dr_prev_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cfg_q     <= '0;
         total_q   <= '0;
         tile_q    <= '0;
         cmpl_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         offer_q   <= '0;
         pbusy_q   <= '0;
      end else begin
         state_q   <= state_d;
         dr_prev_q <= dr_prev_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cfg_q     <= cfg_d;
         total_q   <= total_d;
         tile_q    <= tile_d;
         cmpl_q    <= cmpl_d;
         row_q     <= row_d;
         col_q     <= col_d;
         offer_q   <= offer_d;
         pbusy_q   <= pbusy_d;
      end
   end

   assign o_Config        = cfg_q;
   assign o_Row_Index     = row_q;
   assign o_Column_Index  = col_q;
   assign o_Indexes_Ready = offer_q;
   assign o_Busy          = busy_q;
   assign o_Done          = done_q;
   assign o_Error         = err_q;

endmodule
